// File: rtl/pht_port_scheduler.sv
// pht_port_scheduler
//   Owns the single-ported pattern-history table (PHT) SRAM of the branch
//   predictor and schedules every access to it. After reset it sweeps the
//   whole table to weakly-not-taken (2'b01). It then serves decoder lookups
//   and applies queued ROB resolution updates as read-modify-write cycles on
//   the 2-bit saturating counters.
//
// Ports
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   rdy_in                           global ready; low = issue nothing new
//   decoder_bp_en_in/_pc_in          lookup request and branch PC
//   bp_ready_out                     lookup presented this cycle is accepted
//   bp_valid_out, bp_taken_out       lookup result, one cycle after accept
//   rob_bp_en_in/_correct_in/_pc_in  resolved-branch update
//   rob_bp_full_out                  update FIFO holds UPD_DEPTH entries
//   bp_overflow_out                  sticky: an update was dropped on a full FIFO
//   pht_ce_out/_we_out/_addr_out/_wdata_out, pht_rdata_in   PHT macro port

module pht_port_scheduler #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_WIDTH = 32,
  parameter int UPD_DEPTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  decoder_bp_en_in,
  input  logic [ADDR_WIDTH-1:0] decoder_bp_pc_in,
  output logic                  bp_ready_out,
  output logic                  bp_valid_out,
  output logic                  bp_taken_out,
  input  logic                  rob_bp_en_in,
  input  logic                  rob_bp_correct_in,
  input  logic [ADDR_WIDTH-1:0] rob_bp_pc_in,
  output logic                  rob_bp_full_out,
  output logic                  bp_overflow_out,
  output logic                  pht_ce_out,
  output logic                  pht_we_out,
  output logic [INDEX_BITS-1:0] pht_addr_out,
  output logic [1:0]            pht_wdata_out,
  input  logic [1:0]            pht_rdata_in
);

  localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W = $clog2(UPD_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(UPD_DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweepPtr_q, sweepPtr_d;

  logic [INDEX_BITS-1:0] fifoIdx_q [UPD_DEPTH];
  logic                  fifoCorrect_q [UPD_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  lookValid_q, lookValid_d;
  logic                  rmwRead_q, rmwRead_d;
  logic                  holdWr_q, holdWr_d;
  logic [1:0]            holdData_q, holdData_d;
  logic [INDEX_BITS-1:0] rmwIdx_q, rmwIdx_d;
  logic                  rmwCorrect_q, rmwCorrect_d;

  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  wrPending;
  logic                  pushReq;
  logic                  pushOk;
  logic                  pop;
  logic [INDEX_BITS-1:0] decIdx;
  logic [INDEX_BITS-1:0] robIdx;
  logic [INDEX_BITS-1:0] headIdx;
  logic                  headCorrect;
  logic [1:0]            oldCtr;
  logic [1:0]            newCtr;
  logic                  ceOut;
  logic                  weOut;
  logic [INDEX_BITS-1:0] addrOut;
  logic [1:0]            wdataOut;
  logic                  readyOut;
  logic                  unusedPcBits;

  // Correct predictions saturate toward the current direction; mispredictions
  // step one state toward the other direction.
  function automatic logic [1:0] nextCounter(input logic [1:0] ctr, input logic correct);
    logic [1:0] res;
    if (correct) begin
      res = ctr[1] ? 2'b11 : 2'b00;
    end else begin
      unique case (ctr)
        2'b00:   res = 2'b01;
        2'b01:   res = 2'b10;
        2'b10:   res = 2'b01;
        default: res = 2'b10;
      endcase
    end
    return res;
  endfunction

  assign decIdx       = decoder_bp_pc_in[INDEX_BITS+1:2];
  assign robIdx       = rob_bp_pc_in[INDEX_BITS+1:2];
  assign unusedPcBits = ^{decoder_bp_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], decoder_bp_pc_in[1:0],
                          rob_bp_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], rob_bp_pc_in[1:0]};

  assign headIdx     = fifoIdx_q[rdPtr_q];
  assign headCorrect = fifoCorrect_q[rdPtr_q];
  assign fifoFull    = (count_q == FULL_COUNT);
  assign fifoEmpty   = (count_q == '0);

  // An RMW write is owed either straight after its read, or later from the
  // latched data when rdy_in dropped in the cycle the read data came back.
  assign wrPending = rmwRead_q | holdWr_q;
  assign oldCtr    = rmwRead_q ? pht_rdata_in : holdData_q;
  assign newCtr    = nextCounter(oldCtr, rmwCorrect_q);

  // Space is judged on the registered count, so a same-cycle pop never frees a slot.
  assign pushReq = rst_n_in & rdy_in & rob_bp_en_in;
  assign pushOk  = pushReq & ~fifoFull;

  // Next-state and port arbitration: sweep in INIT; in RUN the owed write
  // wins, then a full FIFO, then the decoder, then any queued update.
  always_comb begin
    state_d      = state_q;
    sweepPtr_d   = sweepPtr_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    overflow_d   = overflow_q;
    lookValid_d  = 1'b0;
    rmwRead_d    = 1'b0;
    holdWr_d     = holdWr_q;
    holdData_d   = holdData_q;
    rmwIdx_d     = rmwIdx_q;
    rmwCorrect_d = rmwCorrect_q;
    ceOut        = 1'b0;
    weOut        = 1'b0;
    addrOut      = '0;
    wdataOut     = '0;
    readyOut     = 1'b0;
    pop          = 1'b0;

    // Read data is only valid for one cycle, so capture it regardless of rdy_in.
    if (rmwRead_q) begin
      holdWr_d   = 1'b1;
      holdData_d = pht_rdata_in;
    end

    if (rst_n_in && rdy_in) begin
      unique case (state_q)
        ST_INIT: begin
          ceOut      = 1'b1;
          weOut      = 1'b1;
          addrOut    = sweepPtr_q;
          wdataOut   = 2'b01;
          sweepPtr_d = sweepPtr_q + INDEX_BITS'(1);
          if (sweepPtr_q == '1) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          readyOut = ~wrPending & ~fifoFull;
          if (wrPending) begin
            ceOut    = 1'b1;
            weOut    = 1'b1;
            addrOut  = rmwIdx_q;
            wdataOut = newCtr;
            holdWr_d = 1'b0;
          end else if (fifoFull || (!decoder_bp_en_in && !fifoEmpty)) begin
            ceOut        = 1'b1;
            addrOut      = headIdx;
            pop          = 1'b1;
            rmwRead_d    = 1'b1;
            rmwIdx_d     = headIdx;
            rmwCorrect_d = headCorrect;
            rdPtr_d      = rdPtr_q + PTR_W'(1);
          end else if (decoder_bp_en_in) begin
            ceOut       = 1'b1;
            addrOut     = decIdx;
            lookValid_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    if (pushOk) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pushReq && fifoFull) begin
      overflow_d = 1'b1;
    end
  end

  assign count_d = count_q + CNT_W'(pushOk) - CNT_W'(pop);

  // Control state; reset discards any sweep progress, queued or in-flight work.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_INIT;
      sweepPtr_q   <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      lookValid_q  <= 1'b0;
      rmwRead_q    <= 1'b0;
      holdWr_q     <= 1'b0;
      holdData_q   <= '0;
      rmwIdx_q     <= '0;
      rmwCorrect_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweepPtr_q   <= sweepPtr_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      lookValid_q  <= lookValid_d;
      rmwRead_q    <= rmwRead_d;
      holdWr_q     <= holdWr_d;
      holdData_q   <= holdData_d;
      rmwIdx_q     <= rmwIdx_d;
      rmwCorrect_q <= rmwCorrect_d;
    end
  end

  // FIFO payload needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_in) begin
    if (pushOk) begin
      fifoIdx_q[wrPtr_q]     <= robIdx;
      fifoCorrect_q[wrPtr_q] <= rob_bp_correct_in;
    end
  end

  assign bp_ready_out    = readyOut;
  assign bp_valid_out    = lookValid_q;
  assign bp_taken_out    = lookValid_q & pht_rdata_in[1];
  assign rob_bp_full_out = fifoFull;
  assign bp_overflow_out = overflow_q;
  assign pht_ce_out      = ceOut;
  assign pht_we_out      = weOut;
  assign pht_addr_out    = addrOut;
  assign pht_wdata_out   = wdataOut;

endmodule

// File: tb/tb_pht_port_scheduler.sv
// tb_pht_port_scheduler
//   Drives pht_port_scheduler against a small behavioural PHT macro. The
//   macro returns scrambled read data on every cycle without a read, so any
//   late sampling of read data shows up. Directed sequences plus a randomized
//   run compared with a queue-based reference model.

`timescale 1ns/1ps

module tb_pht_port_scheduler;

  localparam int IB      = 7;
  localparam int AW      = 32;
  localparam int DEPTH   = 4;
  localparam int ENTRIES = 1 << IB;

  logic          clk;
  logic          rstN;
  logic          rdy;
  logic          decEn;
  logic [AW-1:0] decPc;
  logic          robEn;
  logic          robCorrect;
  logic [AW-1:0] robPc;
  logic          bpReady;
  logic          bpValid;
  logic          bpTaken;
  logic          robFull;
  logic          bpOverflow;
  logic          phtCe;
  logic          phtWe;
  logic [IB-1:0] phtAddr;
  logic [1:0]    phtWdata;
  logic [1:0]    phtRdata;

  logic [1:0]    sram [ENTRIES];

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] pc;
    logic        correct;
    logic [1:0]  expCtr;
  } updVec_t;

  typedef struct {
    logic decEn;
    logic expCe;
    logic expWe;
    int   expAddr;
    int   expWdata;
    logic expReady;
  } seqVec_t;

  typedef struct {
    int idx;
    bit correct;
  } updRec_t;

  pht_port_scheduler #(
    .INDEX_BITS(IB),
    .ADDR_WIDTH(AW),
    .UPD_DEPTH (DEPTH)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rstN),
    .rdy_in           (rdy),
    .decoder_bp_en_in (decEn),
    .decoder_bp_pc_in (decPc),
    .bp_ready_out     (bpReady),
    .bp_valid_out     (bpValid),
    .bp_taken_out     (bpTaken),
    .rob_bp_en_in     (robEn),
    .rob_bp_correct_in(robCorrect),
    .rob_bp_pc_in     (robPc),
    .rob_bp_full_out  (robFull),
    .bp_overflow_out  (bpOverflow),
    .pht_ce_out       (phtCe),
    .pht_we_out       (phtWe),
    .pht_addr_out     (phtAddr),
    .pht_wdata_out    (phtWdata),
    .pht_rdata_in     (phtRdata)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHT macro model: read data is valid only in the cycle after a read.
  always @(posedge clk) begin
    if (phtCe && !phtWe) phtRdata <= sram[phtAddr];
    else                 phtRdata <= 2'($urandom);
    if (phtCe && phtWe)  sram[phtAddr] <= phtWdata;
  end

  // Guard against a hung run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int idxOf(input logic [31:0] pc);
    return int'(pc[IB+1:2]);
  endfunction

  function automatic int nextCtr(input int c, input bit correct);
    if (correct) return (c >= 2) ? 3 : 0;
    return (c < 2) ? c + 1 : c - 1;
  endfunction

  function automatic logic [31:0] randPc(input int maxIdx);
    logic [31:0] p;
    p = $urandom;
    p[IB+1:2] = IB'($urandom_range(0, maxIdx));
    return p;
  endfunction

  task automatic applyStimulus(input logic r, input logic de, input logic [31:0] dp,
                               input logic re, input logic rc, input logic [31:0] rp);
    rdy        = r;
    decEn      = de;
    decPc      = dp;
    robEn      = re;
    robCorrect = rc;
    robPc      = rp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkPort(input string tag, input logic expCe, input logic expWe,
                           input int expAddr, input int expWdata);
    checkOutput({tag, ".ce"}, 32'(phtCe), 32'(expCe));
    if (expCe) begin
      checkOutput({tag, ".we"}, 32'(phtWe), 32'(expWe));
      checkOutput({tag, ".addr"}, 32'(phtAddr), expAddr);
      if (expWe) checkOutput({tag, ".wdata"}, 32'(phtWdata), expWdata);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ce"}, 32'(phtCe), 0);
    checkOutput({tag, ".we"}, 32'(phtWe), 0);
    checkOutput({tag, ".addr"}, 32'(phtAddr), 0);
    checkOutput({tag, ".wdata"}, 32'(phtWdata), 0);
    checkOutput({tag, ".ready"}, 32'(bpReady), 0);
    checkOutput({tag, ".valid"}, 32'(bpValid), 0);
    checkOutput({tag, ".taken"}, 32'(bpTaken), 0);
    checkOutput({tag, ".full"}, 32'(robFull), 0);
    checkOutput({tag, ".overflow"}, 32'(bpOverflow), 0);
  endtask

  task automatic doReset();
    nextCycle();
    rstN = 1'b0;
    idle();
    @(negedge clk);
    checkAllZero("reset");
    nextCycle();
    rstN = 1'b1;
  endtask

  task automatic fullSweep(input string tag);
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      checkPort(tag, 1'b1, 1'b1, i, 1);
      checkOutput({tag, ".ready"}, 32'(bpReady), 0);
      nextCycle();
    end
  endtask

  task automatic doLookup(input logic [31:0] pc, input logic expTaken);
    applyStimulus(1'b1, 1'b1, pc, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("lookup.ready", 32'(bpReady), 1);
    checkPort("lookup.read", 1'b1, 1'b0, idxOf(pc), 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("lookup.valid", 32'(bpValid), 1);
    checkOutput("lookup.taken", 32'(bpTaken), 32'(expTaken));
    nextCycle();
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic correct, input logic [1:0] expCtr);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, correct, pc);
    @(negedge clk);
    checkPort("upd.push", 1'b0, 1'b0, 0, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkPort("upd.read", 1'b1, 1'b0, idxOf(pc), 0);
    checkOutput("upd.readReady", 32'(bpReady), 1);
    nextCycle();
    @(negedge clk);
    checkPort("upd.write", 1'b1, 1'b1, idxOf(pc), int'(expCtr));
    checkOutput("upd.writeReady", 32'(bpReady), 0);
    nextCycle();
  endtask

  initial begin
    updVec_t     updTable [10];
    seqVec_t     drainSeq [10];
    logic [31:0] pushPc [5];
    logic        pushCorrect [5];
    int          refPht [ENTRIES];
    updRec_t     updQ [$];
    updRec_t     pend;
    updRec_t     rec;
    bit          pendValid;
    bit          lookPend;
    bit          lookTaken;
    bit          newLook;
    bit          newTaken;
    bit          mOvf;
    bit          full;
    int          action;
    int          expAddr;
    int          expWdata;
    int          sizeBefore;
    logic        r;
    logic        de;
    logic        re;
    logic        rc;
    logic [31:0] dp;
    logic [31:0] rp;

    // Counter walk on idx 16 covering all eight transitions.
    updTable[0] = '{32'h40, 1'b0, 2'b10};
    updTable[1] = '{32'h40, 1'b0, 2'b01};
    updTable[2] = '{32'h40, 1'b1, 2'b00};
    updTable[3] = '{32'h40, 1'b1, 2'b00};
    updTable[4] = '{32'h40, 1'b0, 2'b01};
    updTable[5] = '{32'h40, 1'b0, 2'b10};
    updTable[6] = '{32'h40, 1'b1, 2'b11};
    updTable[7] = '{32'h40, 1'b1, 2'b11};
    updTable[8] = '{32'h40, 1'b0, 2'b10};
    updTable[9] = '{32'h40, 1'b0, 2'b01};

    pushPc[0] = 32'h40; pushCorrect[0] = 1'b0;
    pushPc[1] = 32'h44; pushCorrect[1] = 1'b0;
    pushPc[2] = 32'h48; pushCorrect[2] = 1'b1;
    pushPc[3] = 32'h4C; pushCorrect[3] = 1'b0;
    pushPc[4] = 32'h50; pushCorrect[4] = 1'b0;

    // Post-sweep drain of a full FIFO with a pending lookup of pc 0x4.
    drainSeq[0] = '{1'b1, 1'b1, 1'b0, 16, 0, 1'b0};
    drainSeq[1] = '{1'b1, 1'b1, 1'b1, 16, 2, 1'b0};
    drainSeq[2] = '{1'b1, 1'b1, 1'b0,  1, 0, 1'b1};
    drainSeq[3] = '{1'b0, 1'b1, 1'b0, 17, 0, 1'b1};
    drainSeq[4] = '{1'b0, 1'b1, 1'b1, 17, 2, 1'b0};
    drainSeq[5] = '{1'b0, 1'b1, 1'b0, 18, 0, 1'b1};
    drainSeq[6] = '{1'b0, 1'b1, 1'b1, 18, 0, 1'b0};
    drainSeq[7] = '{1'b0, 1'b1, 1'b0, 19, 0, 1'b1};
    drainSeq[8] = '{1'b0, 1'b1, 1'b1, 19, 2, 1'b0};
    drainSeq[9] = '{1'b0, 1'b0, 1'b0,  0, 0, 1'b1};

    // Reset, full sweep, first lookup.
    rstN = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkAllZero("reset");
    nextCycle();
    rstN = 1'b1;
    fullSweep("sweep");
    doLookup(32'h40, 1'b0);

    // Counter transitions, each followed by a lookup of the same entry.
    foreach (updTable[k]) begin
      doUpdate(updTable[k].pc, updTable[k].correct, updTable[k].expCtr);
      doLookup(updTable[k].pc, updTable[k].expCtr[1]);
    end

    // Update and lookup in the same idle cycle: lookup reads first.
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8);
    @(negedge clk);
    checkOutput("same.ready", 32'(bpReady), 1);
    checkPort("same.lookup", 1'b1, 1'b0, 1, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("same.valid", 32'(bpValid), 1);
    checkOutput("same.taken", 32'(bpTaken), 0);
    checkPort("same.rmwRead", 1'b1, 1'b0, 2, 0);
    nextCycle();
    @(negedge clk);
    checkPort("same.rmwWrite", 1'b1, 1'b1, 2, 2);
    nextCycle();

    // rdy_in low for three cycles between RMW read and write.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40);
    nextCycle();
    idle();
    @(negedge clk);
    checkPort("stall.read", 1'b1, 1'b0, 16, 0);
    nextCycle();
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkPort("stall.hold", 1'b0, 1'b0, 0, 0);
      checkOutput("stall.ready", 32'(bpReady), 0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkPort("stall.write", 1'b1, 1'b1, 16, 2);
    checkOutput("stall.writeReady", 32'(bpReady), 0);
    nextCycle();

    // Five pushes during INIT: fourth fills, fifth is dropped.
    doReset();
    for (int i = 0; i < ENTRIES; i++) begin
      if (i < 5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, pushCorrect[i], pushPc[i]);
      else       idle();
      @(negedge clk);
      checkPort("initPush.sweep", 1'b1, 1'b1, i, 1);
      if (i < 7) begin
        checkOutput("initPush.full", 32'(robFull), (i >= 4) ? 1 : 0);
        checkOutput("initPush.overflow", 32'(bpOverflow), (i >= 5) ? 1 : 0);
      end
      nextCycle();
    end
    foreach (drainSeq[k]) begin
      applyStimulus(1'b1, drainSeq[k].decEn, 32'h4, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkPort("drain", drainSeq[k].expCe, drainSeq[k].expWe, drainSeq[k].expAddr, drainSeq[k].expWdata);
      checkOutput("drain.ready", 32'(bpReady), 32'(drainSeq[k].expReady));
      checkOutput("drain.valid", 32'(bpValid), (k == 3) ? 1 : 0);
      if (k == 3) checkOutput("drain.taken", 32'(bpTaken), 0);
      nextCycle();
    end
    checkOutput("drain.overflowSticky", 32'(bpOverflow), 1);

    // Reset asserted mid-sweep at ptr 50 with a full FIFO and overflow set.
    doReset();
    for (int i = 0; i < 50; i++) begin
      if (i < 5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h60 + 32'(4 * i));
      else       idle();
      nextCycle();
    end
    @(negedge clk);
    checkPort("midReset.ptr50", 1'b1, 1'b1, 50, 1);
    checkOutput("midReset.fullBefore", 32'(robFull), 1);
    checkOutput("midReset.overflowBefore", 32'(bpOverflow), 1);
    #1;
    rstN = 1'b0;
    #1;
    checkAllZero("midReset");
    nextCycle();
    rstN = 1'b1;
    fullSweep("resweep");
    @(negedge clk);
    checkPort("resweep.idle", 1'b0, 1'b0, 0, 0);
    checkOutput("resweep.ready", 32'(bpReady), 1);
    checkOutput("resweep.full", 32'(robFull), 0);
    nextCycle();

    // Randomized traffic against the reference model (table is all 01 here).
    for (int i = 0; i < ENTRIES; i++) refPht[i] = 1;
    pendValid = 1'b0;
    lookPend  = 1'b0;
    lookTaken = 1'b0;
    mOvf      = 1'b0;
    pend      = '{0, 1'b0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r  = ($urandom_range(0, 9) != 0);
      de = 1'($urandom_range(0, 1));
      dp = randPc(7);
      re = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rp = randPc(7);
      applyStimulus(r, de, dp, re, rc, rp);

      full     = (updQ.size() == DEPTH);
      action   = 0;
      expAddr  = 0;
      expWdata = 0;
      if (r) begin
        if (pendValid) begin
          action   = 1;
          expAddr  = pend.idx;
          expWdata = nextCtr(refPht[pend.idx], pend.correct);
        end else if (full || (!de && updQ.size() > 0)) begin
          action  = 2;
          expAddr = updQ[0].idx;
        end else if (de) begin
          action  = 3;
          expAddr = idxOf(dp);
        end
      end

      @(negedge clk);
      checkOutput("rand.ready", 32'(bpReady), (r && !pendValid && !full) ? 1 : 0);
      checkPort("rand", (action != 0), (action == 1), expAddr, expWdata);
      checkOutput("rand.valid", 32'(bpValid), 32'(lookPend));
      if (lookPend) checkOutput("rand.taken", 32'(bpTaken), 32'(lookTaken));
      checkOutput("rand.full", 32'(robFull), 32'(full));
      checkOutput("rand.overflow", 32'(bpOverflow), 32'(mOvf));

      sizeBefore = updQ.size();
      newLook    = 1'b0;
      newTaken   = 1'b0;
      case (action)
        1: begin
          refPht[pend.idx] = expWdata;
          pendValid = 1'b0;
        end
        2: begin
          pend      = updQ.pop_front();
          pendValid = 1'b1;
        end
        3: begin
          newLook  = 1'b1;
          newTaken = (refPht[expAddr] >= 2);
        end
        default: begin
        end
      endcase
      if (re && r) begin
        if (sizeBefore < DEPTH) begin
          rec = '{idxOf(rp), rc};
          updQ.push_back(rec);
        end else begin
          mOvf = 1'b1;
        end
      end
      lookPend  = newLook;
      lookTaken = newTaken;
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
